// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one Avalon-style bus with waitrequest between the CPU instruction-fetch
// port and data port. It runs one transaction at a time and holds bus outputs until the slave accepts.
module mips_cpu_mem_arbiter #(
   parameter bit FAIR = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_read,
   input  logic [31:0] i_address,
   output logic [31:0] i_readdata,
   output logic        i_waitrequest,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_address,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic [31:0] d_readdata,
   output logic        d_waitrequest,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   input  logic        waitrequest,
   output logic [1:0]  owner
);

   // state | meaning
   // IDLE  | no grant; sample requests and arbitrate
   // INSTR | instruction fetch owns the bus until waitrequest drops
   // DATA  | data port owns the bus until waitrequest drops
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      INSTR = 2'b01,
      DATA  = 2'b10
   } state_t;

   state_t state;
   logic   last_data;
   logic   d_req;
   logic   pick_instr;

   assign d_req = d_read | d_write;
   // On a tie, instruction wins only in fair mode when data was served last
   assign pick_instr = i_read & (~d_req | (FAIR & last_data));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= 2'b00;
         last_data  <= 1'b1;
         read       <= 1'b0;
         write      <= 1'b0;
         address    <= 32'd0;
         writedata  <= 32'd0;
         byteenable <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_instr) begin
                  state      <= INSTR;
                  owner      <= 2'b01;
                  read       <= 1'b1;
                  write      <= 1'b0;
                  address    <= i_address;
                  byteenable <= 4'b1111;
               end else if (d_req) begin
                  state      <= DATA;
                  owner      <= 2'b10;
                  read       <= ~d_write;
                  write      <= d_write;
                  address    <= d_address;
                  writedata  <= d_writedata;
                  byteenable <= d_byteenable;
               end else begin
                  read  <= 1'b0;
                  write <= 1'b0;
               end
            end
            INSTR, DATA: begin
               if (!waitrequest) begin
                  state     <= IDLE;
                  owner     <= 2'b00;
                  read      <= 1'b0;
                  write     <= 1'b0;
                  last_data <= (state == DATA);
               end
            end
            default: begin
               state <= IDLE;
               owner <= 2'b00;
               read  <= 1'b0;
               write <= 1'b0;
            end
         endcase
      end
   end

   assign i_waitrequest = i_read & ~((state == INSTR) & ~waitrequest);
   assign d_waitrequest = d_req  & ~((state == DATA)  & ~waitrequest);
   assign i_readdata    = readdata;
   assign d_readdata    = readdata;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter; fair (_f) and data-priority (_p) instances share stimulus.
module tb_mips_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_read, d_read, d_write, waitrequest;
   logic [31:0] i_address, d_address, d_writedata, readdata;
   logic [3:0]  d_byteenable;

   logic [31:0] i_readdata_f, d_readdata_f, address_f, writedata_f;
   logic        i_waitrequest_f, d_waitrequest_f, read_f, write_f;
   logic [3:0]  byteenable_f;
   logic [1:0]  owner_f;

   logic [31:0] i_readdata_p, d_readdata_p, address_p, writedata_p;
   logic        i_waitrequest_p, d_waitrequest_p, read_p, write_p;
   logic [3:0]  byteenable_p;
   logic [1:0]  owner_p;

   int passes = 0;
   int total  = 0;

   always #5 clk = ~clk;

   mips_cpu_mem_arbiter #(.FAIR(1'b1)) dut_f (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata_f), .i_waitrequest(i_waitrequest_f),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
      .d_byteenable(d_byteenable), .d_readdata(d_readdata_f), .d_waitrequest(d_waitrequest_f),
      .address(address_f), .read(read_f), .write(write_f), .writedata(writedata_f),
      .byteenable(byteenable_f), .readdata(readdata), .waitrequest(waitrequest), .owner(owner_f)
   );

   mips_cpu_mem_arbiter #(.FAIR(1'b0)) dut_p (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata_p), .i_waitrequest(i_waitrequest_p),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
      .d_byteenable(d_byteenable), .d_readdata(d_readdata_p), .d_waitrequest(d_waitrequest_p),
      .address(address_p), .read(read_p), .write(write_p), .writedata(writedata_p),
      .byteenable(byteenable_p), .readdata(readdata), .waitrequest(waitrequest), .owner(owner_p)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic clear_req();
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
   endtask

   initial begin : stim
      logic [1:0] fair_seq [7];
      fair_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

      reset = 1'b0; clear_req(); waitrequest = 1'b0; readdata = 32'd0;
      i_address = 32'd0; d_address = 32'd0; d_writedata = 32'd0; d_byteenable = 4'd0;
      tick(); tick();
      chk("rst_read",  32'(read_f), 0);
      chk("rst_write", 32'(write_f), 0);
      chk("rst_addr",  address_f, 0);
      chk("rst_be",    32'(byteenable_f), 0);
      chk("rst_owner", 32'(owner_f), 0);
      chk("rst_iwait_idle", 32'(i_waitrequest_f), 0);
      i_read = 1'b1; #1;
      chk("rst_iwait_req", 32'(i_waitrequest_f), 1);
      i_read = 1'b0;
      reset = 1'b1;
      tick();

      // single instruction read, zero-wait
      i_read = 1'b1; i_address = 32'hBFC00000; readdata = 32'h24020005;
      tick();
      chk("ir_read",  32'(read_f), 1);
      chk("ir_write", 32'(write_f), 0);
      chk("ir_addr",  address_f, 32'hBFC00000);
      chk("ir_be",    32'(byteenable_f), 32'hF);
      chk("ir_owner", 32'(owner_f), 1);
      chk("ir_iwait", 32'(i_waitrequest_f), 0);
      chk("ir_rdata", i_readdata_f, 32'h24020005);
      clear_req();
      tick();
      chk("ir_read_off", 32'(read_f), 0);
      chk("ir_owner_off", 32'(owner_f), 0);

      // data write with 3 wait states
      d_write = 1'b1; d_address = 32'h1000; d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
      waitrequest = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) begin
            waitrequest = 1'b0; #1;
         end
         chk($sformatf("dw_write_c%0d", c), 32'(write_f), 1);
         chk($sformatf("dw_read_c%0d", c),  32'(read_f), 0);
         chk($sformatf("dw_addr_c%0d", c),  address_f, 32'h1000);
         chk($sformatf("dw_wdata_c%0d", c), writedata_f, 32'hDEADBEEF);
         chk($sformatf("dw_be_c%0d", c),    32'(byteenable_f), 32'h3);
         chk($sformatf("dw_owner_c%0d", c), 32'(owner_f), 2);
         chk($sformatf("dw_dwait_c%0d", c), 32'(d_waitrequest_f), (c == 4) ? 0 : 1);
      end
      clear_req();
      tick();
      chk("dw_write_off", 32'(write_f), 0);

      // read+write together is a write
      d_read = 1'b1; d_write = 1'b1; d_address = 32'h2000;
      tick();
      chk("rw_write", 32'(write_f), 1);
      chk("rw_read",  32'(read_f), 0);
      chk("rw_addr",  address_f, 32'h2000);
      clear_req();
      tick();

      // reset during a stalled data read
      d_read = 1'b1; d_address = 32'h4000; waitrequest = 1'b1;
      tick();
      chk("sr_read",  32'(read_f), 1);
      chk("sr_owner", 32'(owner_f), 2);
      tick();
      i_read = 1'b1; reset = 1'b0; #1;
      chk("sr_dwait_stall", 32'(d_waitrequest_f), 1);
      tick();
      chk("sr_read_rst",  32'(read_f), 0);
      chk("sr_owner_rst", 32'(owner_f), 0);
      chk("sr_addr_rst",  address_f, 0);
      chk("sr_iwait_rst", 32'(i_waitrequest_f), 1);
      reset = 1'b1; waitrequest = 1'b0; i_address = 32'hBFC00010;
      tick();
      chk("sr_first_owner", 32'(owner_f), 1);
      chk("sr_first_addr",  address_f, 32'hBFC00010);
      clear_req();
      tick();

      // data-priority tie: data first, then instruction once data drops
      reset = 1'b0; tick(); reset = 1'b1;
      i_read = 1'b1; d_read = 1'b1; i_address = 32'hBFC00000; d_address = 32'h3000;
      tick();
      chk("p_owner1", 32'(owner_p), 2);
      chk("p_dwait1", 32'(d_waitrequest_p), 0);
      chk("p_iwait1", 32'(i_waitrequest_p), 1);
      d_read = 1'b0;
      tick();
      chk("p_owner_idle", 32'(owner_p), 0);
      tick();
      chk("p_owner2", 32'(owner_p), 1);
      chk("p_iwait2", 32'(i_waitrequest_p), 0);
      clear_req();
      tick();

      // fair tie with both held: instr, data, instr, data
      reset = 1'b0; tick(); reset = 1'b1;
      i_read = 1'b1; d_read = 1'b1;
      for (int s = 0; s < 7; s++) begin
         tick();
         chk($sformatf("f_owner_s%0d", s), 32'(owner_f), 32'(fair_seq[s]));
         if (fair_seq[s] == 2'b01) chk($sformatf("f_addr_s%0d", s), address_f, 32'hBFC00000);
         if (fair_seq[s] == 2'b10) chk($sformatf("f_addr_s%0d", s), address_f, 32'h3000);
      end
      clear_req();
      tick();

      // long idle
      for (int n = 0; n < 10; n++) tick();
      chk("idle_read",  32'(read_f), 0);
      chk("idle_write", 32'(write_f), 0);
      chk("idle_iwait", 32'(i_waitrequest_f), 0);
      chk("idle_dwait", 32'(d_waitrequest_f), 0);
      chk("idle_owner", 32'(owner_f), 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

Two-port to one-port memory arbiter. It lets the Harvard CPU's instruction-fetch port and data port share a single Avalon-style memory bus with `waitrequest`. It sits between `mips_cpu_harvard`-style instruction/data ports and the unified memory. It sequences one bus transaction at a time, arbitrates simultaneous requests, and holds every bus signal stable until the slave accepts.

## Interface

Parameters:
- `FAIR`, default 1: 1 = round-robin between ports on a tie; 0 = data port always wins a tie.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-low.
- `i_read` in 1: instruction read request; held until completion.
- `i_address` in 32: instruction address.
- `i_readdata` out 32: instruction read data; valid in the cycle `i_waitrequest` is low with `i_read` high.
- `i_waitrequest` out 1: instruction port stall.
- `d_read` in 1: data read request.
- `d_write` in 1: data write request.
- `d_address` in 32: data address.
- `d_writedata` in 32: data write data.
- `d_byteenable` in 4: data byte enables.
- `d_readdata` out 32: data read data.
- `d_waitrequest` out 1: data port stall.
- `address` out 32: bus address (registered).
- `read` out 1: bus read (registered).
- `write` out 1: bus write (registered).
- `writedata` out 32: bus write data (registered).
- `byteenable` out 4: bus byte enables (registered).
- `readdata` in 32: bus read data.
- `waitrequest` in 1: bus stall from the slave.
- `owner` out 2: current grant; 00 none, 01 instruction, 10 data.

## Operation

- FSM states: `IDLE` (owner 00), `INSTR` (owner 01), `DATA` (owner 10).
- `IDLE` transitions:
  - No request pending: stay in `IDLE`, bus `read`/`write` = 0.
  - Exactly one port requesting: grant that port at the edge, register its command onto the bus, and move to `INSTR` or `DATA`.
  - Both ports requesting with `FAIR`=1: grant the port not granted last. The `last_grant` register resets to data, so instruction wins the first tie.
  - Both ports requesting with `FAIR`=0: grant data.
- Instruction grant drives the bus with `read`=1, `write`=0, `address`=`i_address`, `byteenable`=4'b1111, `writedata` unchanged.
- Data grant:
  - `d_write`=1: bus `write`=1, `read`=0.
  - Otherwise (`d_read`=1): bus `read`=1, `write`=0.
  - `d_read` and `d_write` both high is treated as a write only.
  - `address`, `writedata` and `byteenable` are copied from the data port.
- `INSTR`/`DATA`: the bus registers are frozen while `waitrequest`=1. The first cycle with `waitrequest`=0 is the completion cycle:
  - The owning port's waitrequest is low in that cycle.
  - Its readdata equals bus `readdata` combinationally.
  - At the next edge: `read`/`write` go to 0, `last_grant` is updated, state returns to `IDLE`.
- Port waitrequest (combinational):
  - `i_waitrequest = i_read & !(state==INSTR & !waitrequest)`.
  - `d_waitrequest = (d_read|d_write) & !(state==DATA & !waitrequest)`.
- Port readdata buses always mirror bus `readdata`. They are meaningful only in the completion cycle.
- No address alignment checks and no modification of addresses or data.
- Requesters hold their command stable while their waitrequest is high, and drop or replace it after completion. A request withdrawn while in `IDLE` is simply not granted.
- Reset (`reset`=0 at an edge):
  - State `IDLE`; `read`=0, `write`=0, `address`=0, `writedata`=0, `byteenable`=0; `owner`=00; `last_grant`=data.
  - An in-flight bus transaction is abandoned, even mid-stall; no completion is signalled.
  - While reset is held, port waitrequests follow the combinational equations with state `IDLE`.

## Timing

- A request first sampled at edge k has bus command valid from cycle k+1.
- With a zero-wait slave, the port completes in cycle k+1: 2-cycle latency, one transaction per 2 cycles, one `IDLE` cycle between grants.
- Each bus wait-state cycle adds one cycle of latency.
- A request arriving in the completion cycle of the other port is sampled in the following `IDLE` cycle.
- Bus outputs are registered; the only combinational paths are `waitrequest`/`readdata` to the port outputs.

## Test plan

- Single instruction read, zero-wait slave, `i_address`=32'hBFC00000:
  - Cycle 1: `read`=1, `address`=BFC00000, `byteenable`=F, `owner`=01.
  - Slave `readdata`=32'h24020005: `i_readdata`=24020005 and `i_waitrequest`=0 in that cycle; `read`=0 next cycle.
- Data write with 3 wait states, `d_address`=32'h1000, `d_writedata`=32'hDEADBEEF, `d_byteenable`=4'b0011:
  - Bus signals stable for 4 cycles; `d_waitrequest` low only in the 4th.
  - `write`=1 and `read`=0 throughout.
- Tie arbitration, both ports requesting continuously:
  - `FAIR`=1: grant order instr, data, instr, data.
  - `FAIR`=0: data completes first, then instr.
- `d_read`=`d_write`=1 at `d_address`=32'h2000: bus `write`=1, `read`=0.
- Reset low during a stalled data read (`waitrequest`=1):
  - Next cycle: `read`=0, `owner`=00, `address`=0.
  - After reset release with `i_read` high: instruction is granted first.
- No requests for 10 cycles: `read`=`write`=0, both port waitrequests 0, `owner`=00.
